// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
// FSM state encoding plus iteration and latency counts.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_STEPS   = 32;
    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
// The master modport is the pipeline side; the slave modport is the divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic                 flush;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, is_signed, flush, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, is_signed, flush, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, dvd} left by one,
// then subtract the divisor when the widened remainder covers it.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;

    assign shifted  = {rem, dvd[WIDTH-1]};
    assign q_bit    = (shifted >= {1'b0, dvs});
    // When the subtract happens the true difference is below dvs, so the
    // narrow subtraction cannot lose a carry.
    assign rem_next = q_bit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    assign dvd_next = {dvd[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per cycle, then a sign fixup
// cycle, producing {remainder, quotient} for HI/LO.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int CW = $clog2(DIV_STEPS);

    div_state_t          state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0]    rem_reg, rem_next;
    logic [WIDTH-1:0]    dvd_reg, dvd_next;
    logic [WIDTH-1:0]    dvs_reg, dvs_next;
    logic [WIDTH-1:0]    a_orig_reg, a_orig_next;
    logic                qsign_reg, qsign_next;
    logic                rsign_reg, rsign_next;
    logic                dbz_reg, dbz_next;
    logic                signed_reg, signed_next;
    logic [2*WIDTH-1:0]  result_reg, result_next;

    logic [WIDTH-1:0]    step_rem, step_dvd;
    logic                step_q;
    logic [WIDTH-1:0]    q_fix, r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd      (dvd_reg),
        .dvs      (dvs_reg),
        .rem_next (step_rem),
        .dvd_next (step_dvd),
        .q_bit    (step_q)
    );

    // Divide-by-zero bypasses the fixup so the raw all-ones quotient survives.
    assign q_fix = (signed_reg && qsign_reg && !dbz_reg) ? -dvd_reg : dvd_reg;
    assign r_fix = dbz_reg ? a_orig_reg
                 : ((signed_reg && rsign_reg) ? -rem_reg : rem_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            a_orig_reg <= '0;
            qsign_reg  <= 1'b0;
            rsign_reg  <= 1'b0;
            dbz_reg    <= 1'b0;
            signed_reg <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            dvd_reg    <= dvd_next;
            dvs_reg    <= dvs_next;
            a_orig_reg <= a_orig_next;
            qsign_reg  <= qsign_next;
            rsign_reg  <= rsign_next;
            dbz_reg    <= dbz_next;
            signed_reg <= signed_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        dvd_next    = dvd_reg;
        dvs_next    = dvs_reg;
        a_orig_next = a_orig_reg;
        qsign_next  = qsign_reg;
        rsign_next  = rsign_reg;
        dbz_next    = dbz_reg;
        signed_next = signed_reg;
        result_next = result_reg;

        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_next  = DIV;
                        cnt_next    = '0;
                        rem_next    = '0;
                        dvd_next    = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        dvs_next    = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        a_orig_next = bus.a;
                        qsign_next  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rsign_next  = bus.a[WIDTH-1];
                        dbz_next    = (bus.b == '0);
                        signed_next = bus.is_signed;
                    end else begin
                        state_next = IDLE;
                    end
                end
                DIV: begin
                    rem_next = step_rem;
                    dvd_next = step_dvd | WIDTH'(step_q);
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(DIV_STEPS - 1)) begin
                        state_next = FIX;
                    end
                end
                FIX: begin
                    result_next = {r_fix, q_fix};
                    state_next  = DONE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.busy   = (state_reg == DIV) || (state_reg == FIX);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
endmodule

// File: tb/tb_div_unit.sv
// Directed checks for div_unit: arithmetic vectors, latency, flush,
// back-to-back issue, ignored mid-operation start and asynchronous reset.
module tb_div_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one divide from the current cycle and waits for done.
    // poke > 0 re-asserts start with junk operands in that cycle of the run.
    task automatic do_div(input string tag, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input int poke);
        int n;
        int busy_cnt;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.a         = x;
        bus.b         = y;
        tick();
        bus.start = 1'b0;
        n         = 1;
        busy_cnt  = 0;
        while (n <= 40) begin
            if (poke > 0 && n == poke) begin
                bus.start     = 1'b1;
                bus.is_signed = ~s;
                bus.a         = 32'h0BAD0BAD;
                bus.b         = 32'd1;
            end
            if (poke > 0 && n == poke + 1) bus.start = 1'b0;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd34);
        check({tag, "_busy"}, 64'(busy_cnt), 64'd33);
        check({tag, "_res"}, bus.result, exp);
    endtask

    initial begin
        int done_seen;
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.flush     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", bus.result, 64'd0);
        rst = 1'b1;
        tick();

        do_div("u100_7",   1'b0, 32'd100,      32'd7,        {32'd2, 32'd14}, 0);
        tick();
        check("done_pulse", 64'(bus.done), 64'd0);
        do_div("s_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        tick();
        do_div("s_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0);
        tick();
        do_div("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0);
        tick();
        do_div("u_5_0",    1'b0, 32'd5,        32'd0,        {32'h5, 32'hFFFFFFFF}, 0);
        tick();
        do_div("s_5_0",    1'b1, 32'd5,        32'd0,        {32'h5, 32'hFFFFFFFF}, 0);
        tick();
        do_div("s_m7_0",   1'b1, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 0);
        tick();
        do_div("u_big_2",  1'b0, 32'hFFFFFFF9, 32'd2,        {32'h1, 32'h7FFFFFFC}, 0);
        tick();

        // Flush in cycle 10 of a 100/7 run; result must keep the previous value.
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_done", 64'(bus.done), 64'd0);
        check("flush_result", bus.result, {32'h1, 32'h7FFFFFFC});
        done_seen = 0;
        repeat (40) begin
            if (bus.done) done_seen++;
            tick();
        end
        check("flush_nodone", 64'(done_seen), 64'd0);

        do_div("u9_3",     1'b0, 32'd9,   32'd3, {32'd0, 32'd3}, 0);
        tick();
        // Back-to-back: the second start is raised in the first op's done cycle.
        do_div("b2b_a",    1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        do_div("b2b_b",    1'b0, 32'd20,  32'd6, {32'd2, 32'd3}, 5);
        tick();
        check("after_b2b_done", 64'(bus.done), 64'd0);
        check("after_b2b_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset dropped between clock edges mid-divide.
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd1000;
        bus.b         = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("pre_arst_busy", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_result", bus.result, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        do_div("post_rst", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage. Produces the 64-bit {hi, lo} pair that the register file writes into HI/LO with its full-width write flag. It holds the pipeline via `busy` while iterating and pulses `done` for one cycle with the result. It can be cancelled by a pipeline flush.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is used and verified.

Ports:
- `clk` in 1: the block's single clock, rising-edge.
- `rst` in 1: reset, asynchronous and active-low.
- `start` in 1: request a divide. Sampled only in IDLE or DONE.
- `is_signed` in 1: 1 = DIV, 0 = DIVU. Captured with `start`.
- `flush` in 1: cancel any in-flight operation.
- `a` in WIDTH: dividend, captured with `start`.
- `b` in WIDTH: divisor, captured with `start`.
- `busy` out 1: high in DIV and FIX states. The pipeline stalls on it.
- `done` out 1: one-cycle pulse, high in DONE state.
- `result` out 2*WIDTH: {remainder, quotient}, i.e. {hi, lo}. Registered and held until the next completed operation.

## Operation
- States: IDLE, DIV, FIX, DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1 and `flush`=0:
  - Capture |a| and |b|. Absolute value only when `is_signed`=1.
  - Capture the quotient-sign bit `a[31]^b[31]`, the remainder-sign bit `a[31]`, the `b==0` flag, and `is_signed`.
  - Clear the partial remainder; go to DIV with step counter 0.
- IDLE or DONE otherwise: go to (or stay in) IDLE.
- DIV, one quotient bit per cycle, MSB first:
  - Shift {rem, dvd} left by 1.
  - If the upper 33-bit rem ≥ {0, |b|}: subtract and set the quotient bit to 1.
  - After step 31 go to FIX.
- FIX, registers `result` and goes to DONE. Signed case only:
  - Negate the quotient if the quotient-sign bit is set.
  - Negate the remainder if the remainder-sign bit is set.
- Divide by zero (b==0), either mode:
  - Sign fixup is suppressed.
  - Result is quotient = all ones, remainder = a (the original dividend).
  - Full latency still applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. This falls out of 32-bit wrap; no special case.
- Arithmetic width: 33-bit compare/subtract. Negation is two's complement mod 2^32.
- `flush`=1 in any state → IDLE at the next edge. It overrides `start`. `done` is not asserted and `result` is unchanged.
- `start` in DIV or FIX is ignored. A new operation is accepted only in IDLE or DONE.

## Timing
- Reset (async, `rst`=0):
  - state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0.
  - Takes effect immediately, including mid-operation.
- Let start be sampled at edge E0:
  - DIV occupies the cycles after edges E0..E31.
  - FIX follows E32.
  - DONE (`done`=1, `result` valid) follows E33.
- Total latency is 34 cycles from the start-sampling edge to the `done` cycle. It is fixed regardless of operand values.
- `busy` is high for exactly 33 cycles (DIV+FIX) and low in the `done` cycle. The stage consumes `result` in that cycle.
- Back-to-back: `start` in the DONE cycle re-enters DIV at the next edge. `busy` then goes high again with no IDLE gap.
- `result` changes only on the FIX→DONE edge and on reset.

## Structure
- Shared package `div_pkg`:
  - `div_state_t` enum {IDLE, DIV, FIX, DONE}.
  - `localparam DIV_STEPS = 32`.
  - `localparam DIV_LATENCY = 34`.
- Sub-module `div_step`: purely combinational single restoring step. Inputs are {rem, dvd} and divisor; outputs are the next {rem, dvd} and the quotient bit. It is instantiated once in the iteration datapath.
- The FSM, counter, sign capture and fixup stay in `div_unit`.

## Test plan
- Unsigned: `is_signed`=0, a=100, b=7 → `done` exactly 34 cycles after start; `result`={32'd2, 32'd14}. `busy` is high 33 cycles.
- Signed: a=0xFFFFFFF9 (−7), b=2 → `result`={0xFFFFFFFF, 0xFFFFFFFD}. Then a=7, b=0xFFFFFFFE → {0x00000001, 0xFFFFFFFD}.
- Overflow and zero: signed 0x80000000/0xFFFFFFFF → {0, 0x80000000}. Unsigned and signed a=5, b=0 → {0x00000005, 0xFFFFFFFF} after 34 cycles.
- Flush: start 100/7, then `flush`=1 on cycle 10 → `busy`=0 next cycle, no `done` pulse, `result` keeps its prior value. A new start of 9/3 then yields {0, 3}.
- Back-to-back and ignored start: `start` held high in the DONE cycle with 20/6 → second `done` 34 cycles later with {2, 3}. A `start` pulsed mid-DIV changes nothing.
- Async reset: drop `rst` mid-DIV, between clock edges → `busy`, `done`, `result` go to 0 without a clock edge. After release, IDLE accepts a new start.
